// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared BCD digit types and leading-zero mask helper
package sevseg_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BLANK_CODE_DEFAULT = 4'b1111;
    localparam int MAX_DIGITS = 16;
    localparam int MAX_IDX_W = $clog2(MAX_DIGITS);

    typedef logic [BCD_W-1:0] digit_t;

    // Bit i set means digit i is a leading zero; digit 0 is never blanked
    // and codes 10-15 count as significant.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [MAX_DIGITS*BCD_W-1:0] digits,
        input int num
    );
        logic lead;
        lz_mask = '0;
        lead = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < num) begin
                if (i == 0 || digits[i*BCD_W +: BCD_W] != '0) begin
                    lead = 1'b0;
                end
                lz_mask[i] = lead;
            end
        end
    endfunction

endpackage

// File: rtl/sevseg_prescaler.sv
// rtl/sevseg_prescaler.sv - per-slot terminal-count counter with guard window
module sevseg_prescaler #(
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 2
) (
    input  logic clk,
    input  logic rst,
    output logic slot_tick,
    output logic in_guard
);

    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt;

    assign slot_tick = (cnt == CW'(PRESCALE - 1));
    assign in_guard  = (int'(cnt) < GUARD);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (slot_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sevseg_scan.sv
// rtl/sevseg_scan.sv - multiplexed seven-segment scan driver with frame-synchronous load
module sevseg_scan
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int GUARD      = 2,
    parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [4*NUM_DIGITS-1:0]     load_data,
    input  logic                        lz_blank_en,
    output logic [3:0]                  bcd_out,
    output logic [NUM_DIGITS-1:0]       digit_en,
    output logic                        frame_done
);

    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = NUM_DIGITS * BCD_W;

    logic [DW-1:0]               active;
    logic [DW-1:0]               pending;
    logic                        pending_valid;
    logic [SW-1:0]               slot;
    logic [SW-1:0]               next_slot;
    logic                        slot_tick;
    logic                        in_guard;
    logic                        last_slot;
    logic                        boundary;
    logic                        xfer;
    logic [DW-1:0]               next_active;
    logic [MAX_DIGITS*BCD_W-1:0] lz_digits;
    logic [MAX_DIGITS-1:0]       mask;
    digit_t                      next_code;

    sevseg_prescaler #(
        .PRESCALE (PRESCALE),
        .GUARD    (GUARD)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .slot_tick (slot_tick),
        .in_guard  (in_guard)
    );

    assign last_slot  = (slot == SW'(NUM_DIGITS - 1));
    assign boundary   = slot_tick && last_slot;
    assign xfer       = load_valid && !pending_valid;
    assign next_slot  = last_slot ? '0 : slot + 1'b1;

    assign load_ready = !pending_valid;
    assign frame_done = boundary;
    assign digit_en   = in_guard ? '0 : (NUM_DIGITS'(1) << slot);

    // A load landing exactly on the boundary bypasses pending so it is
    // visible in the very next slot 0.
    always_comb begin
        next_active = active;
        if (boundary) begin
            if (pending_valid) begin
                next_active = pending;
            end else if (xfer) begin
                next_active = load_data;
            end
        end
    end

    // Code for the slot about to start, computed from the data that slot will show.
    always_comb begin
        lz_digits = '0;
        lz_digits[DW-1:0] = next_active;
        mask = lz_mask(lz_digits, NUM_DIGITS);
        next_code = next_active[next_slot*BCD_W +: BCD_W];
        if (lz_blank_en && mask[MAX_IDX_W'(next_slot)]) begin
            next_code = BLANK_CODE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot          <= '0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            bcd_out       <= '0;
        end else begin
            active <= next_active;
            if (slot_tick) begin
                slot    <= next_slot;
                bcd_out <= next_code;
            end
            if (boundary) begin
                pending_valid <= 1'b0;
            end else if (xfer) begin
                pending       <= load_data;
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sevseg_scan.sv
// tb/tb_sevseg_scan.sv - randomized and directed self-checking bench for sevseg_scan
module tb_sevseg_scan;

    localparam int N = 4;
    localparam int P = 4;
    localparam int G = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [4*N-1:0] load_data;
    logic          lz_blank_en;
    logic [3:0]    bcd_out;
    logic [N-1:0]  digit_en;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    sevseg_scan #(
        .NUM_DIGITS (N),
        .PRESCALE   (P),
        .GUARD      (G),
        .BLANK_CODE (4'b1111)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .lz_blank_en (lz_blank_en),
        .bcd_out     (bcd_out),
        .digit_en    (digit_en),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: t counts cycles since reset, display data as whole words.
    int          t = 0;
    logic [15:0] mact = '0;
    logic [15:0] mpend = '0;
    bit          mpv = 0;
    logic [3:0]  mbcd = '0;
    bit          model_on = 0;
    bit          bnd;
    bit          xf;
    int          ms;
    int          mc;

    function automatic logic [3:0] shown(input logic [15:0] a, input bit lz, input int s);
        bit lead = 1;
        for (int d = N - 1; d > s; d--) begin
            if (a[4*d +: 4] != 4'd0) lead = 0;
        end
        if (lz && lead && s != 0 && a[4*s +: 4] == 4'd0) return 4'hF;
        return a[4*s +: 4];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t = 0; mact = '0; mpend = '0; mpv = 0; mbcd = '0;
        end else begin
            bnd = ((t / P) % N == N - 1) && (t % P == P - 1);
            xf  = load_valid && !mpv;
            if (bnd) begin
                if (mpv) begin
                    mact = mpend;
                    mpv = 0;
                end else if (xf) begin
                    mact = load_data;
                end
            end else if (xf) begin
                mpend = load_data;
                mpv = 1;
            end
            t++;
            if (t % P == 0) mbcd = shown(mact, lz_blank_en, (t / P) % N);
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            ms = (t / P) % N;
            mc = t % P;
            chk("digit_en", 32'(digit_en), (mc < G) ? 0 : (1 << ms));
            chk("bcd_out", 32'(bcd_out), 32'(mbcd));
            chk("frame_done", 32'(frame_done), 32'(ms == N - 1 && mc == P - 1));
            chk("load_ready", 32'(load_ready), 32'(!mpv));
        end
    end

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 64);
        chk("frame_done_seen", 32'(frame_done), 1);
    endtask

    // Checks slots 0..N-1 of the frame following the current boundary.
    task automatic expect_frame(input logic [15:0] codes, input bit wait_boundary);
        if (wait_boundary) wait_fd();
        repeat (2) @(negedge clk);
        for (int s = 0; s < N; s++) begin
            chk("slot_bcd", 32'(bcd_out), 32'(codes[4*s +: 4]));
            chk("slot_en", 32'(digit_en), 1 << s);
            if (s < N - 1) repeat (P) @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] d);
        @(posedge clk); #1;
        load_valid = 1'b1;
        load_data = d;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        lz_blank_en = 1'b1;

        @(posedge clk); #1;
        model_on = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bcd", 32'(bcd_out), 0);
        chk("rst_en", 32'(digit_en), 0);
        chk("rst_ready", 32'(load_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        chk("first_frame_done_cycles", n, 16);
        expect_frame(16'hFFF0, 0);

        do_load(16'h1234);
        chk("ready_after_load", 32'(load_ready), 0);
        expect_frame(16'h1234, 1);

        do_load(16'h0056);
        expect_frame(16'hFF56, 1);
        lz_blank_en = 1'b0;
        do_load(16'h0056);
        expect_frame(16'h0056, 1);
        lz_blank_en = 1'b1;
        do_load(16'h0000);
        expect_frame(16'hFFF0, 1);
        do_load(16'h0A00);
        expect_frame(16'hFA00, 1);

        wait_fd();
        load_valid = 1'b1;
        load_data = 16'h9876;
        @(posedge clk); #1;
        load_valid = 1'b0;
        chk("ready_direct_load", 32'(load_ready), 1);
        expect_frame(16'h9876, 0);

        wait_fd();
        repeat (3) @(posedge clk);
        do_load(16'h1111);
        do_load(16'h2222);
        chk("ready_pending_full", 32'(load_ready), 0);
        expect_frame(16'h1111, 1);

        lz_blank_en = 1'b0;
        wait_fd();
        repeat (2) @(posedge clk);
        do_load(16'h3333);
        chk("ready_before_rst", 32'(load_ready), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_bcd", 32'(bcd_out), 0);
        chk("midrst_en", 32'(digit_en), 0);
        chk("midrst_ready", 32'(load_ready), 1);
        expect_frame(16'h0000, 1);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            load_valid = ($urandom % 4) == 0;
            load_data = 16'($urandom);
            if ($urandom % 64 == 0) lz_blank_en = ~lz_blank_en;
            rst = ($urandom % 500) == 0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        load_valid = 1'b0;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
